// File: rtl/cp0_ext.sv
// Coprocessor 0 beside the M stage: exception/interrupt entry, EPC/BadVAddr capture, SR/Cause.
// Optional Count/Compare interval timer compiled in with `define CP0_TIMER_EN.
module cp0_ext #(
  parameter int unsigned HWINT_W        = 6,
  parameter logic [31:0] PRID           = 32'h2237_3053,
  parameter int unsigned COUNT_DIV_LOG2 = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               we,
  input  logic [31:0]        cp0_in,
  input  logic [4:0]         reg_wa,
  input  logic [4:0]         reg_ra,
  input  logic [HWINT_W-1:0] hwint,
  input  logic [31:0]        pc,
  input  logic               bd_in,
  input  logic               exl_clr,
  input  logic [4:0]         exc_code_in,
  input  logic [31:0]        bad_vaddr_in,
  output logic               req,
  output logic [31:0]        cp0_out,
  output logic [31:0]        epc_out
);

  localparam int unsigned IP_LSB = 10;

  localparam logic [4:0] A_BADVADDR = 5'd8;
  localparam logic [4:0] A_COUNT    = 5'd9;
  localparam logic [4:0] A_COMPARE  = 5'd11;
  localparam logic [4:0] A_SR       = 5'd12;
  localparam logic [4:0] A_CAUSE    = 5'd13;
  localparam logic [4:0] A_EPC      = 5'd14;
  localparam logic [4:0] A_PRID     = 5'd15;

  localparam logic [4:0] EXC_NONE = 5'h1F;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;

  // Elaboration-time parameter range checks
  if (HWINT_W < 1 || HWINT_W > 6) begin : g_bad_hwint_w
    $error("cp0_ext: HWINT_W must be in 1..6");
  end
  if (COUNT_DIV_LOG2 > 30) begin : g_bad_div
    $error("cp0_ext: COUNT_DIV_LOG2 too large");
  end

  // Architectural state
  logic [HWINT_W-1:0] sr_im;
  logic               sr_exl;
  logic               sr_ie;
  logic               cause_bd;
  logic [HWINT_W-1:0] cause_ip;
  logic [4:0]         cause_exc;
  logic [31:0]        epc;
  logic [31:0]        bad_vaddr;

  logic               ti;
  logic [31:0]        count_rd;
  logic [31:0]        compare_rd;

  logic [HWINT_W-1:0] ip_eff;
  logic               int_req;
  logic               exc_req;
  logic               exc_valid;
  logic               wr_ok;
  logic [31:0]        epc_addr;
  logic [31:0]        epc_next;

  // Timer interrupt shares the highest hardware line
  always_comb begin
    ip_eff            = hwint;
    ip_eff[HWINT_W-1] = hwint[HWINT_W-1] | ti;
  end

  assign exc_valid = (exc_code_in != EXC_NONE) && (exc_code_in != 5'd0);
  assign int_req   = (|(ip_eff & sr_im)) & sr_ie & ~sr_exl;
  assign exc_req   = exc_valid & ~sr_exl;
  assign req       = int_req | exc_req;
  assign wr_ok     = we & ~req;

  assign epc_addr = bd_in ? (pc - 32'd4) : pc;
  assign epc_next = epc_addr & ~32'h3;

  // Exception entry, eret, and mtc0 to SR/EPC
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr_im     <= '0;
      sr_exl    <= 1'b0;
      sr_ie     <= 1'b0;
      cause_bd  <= 1'b0;
      cause_ip  <= '0;
      cause_exc <= 5'd0;
      epc       <= 32'd0;
      bad_vaddr <= 32'd0;
    end else begin
      cause_ip <= hwint;
      if (req) begin
        cause_exc <= int_req ? 5'd0 : exc_code_in;
        sr_exl    <= 1'b1;
        cause_bd  <= bd_in;
        epc       <= epc_next;
        if (!int_req && (exc_code_in == EXC_ADEL || exc_code_in == EXC_ADES)) begin
          bad_vaddr <= bad_vaddr_in;
        end
      end else begin
        if (exl_clr) begin
          sr_exl <= 1'b0;
        end
        if (we) begin
          case (reg_wa)
            A_SR: begin
              sr_im  <= cp0_in[IP_LSB +: HWINT_W];
              sr_exl <= cp0_in[1];
              sr_ie  <= cp0_in[0];
            end
            A_EPC:   epc <= cp0_in;
            default: ;
          endcase
        end
      end
    end
  end

`ifdef CP0_TIMER_EN
  logic [31:0] count;
  logic [31:0] compare;
  logic [31:0] count_inc;
  logic        tick;
  logic        count_wr;
  logic        compare_wr;

  assign count_wr   = wr_ok && (reg_wa == A_COUNT);
  assign compare_wr = wr_ok && (reg_wa == A_COMPARE);
  assign count_inc  = count + 32'd1;

  // Prescaler: divide-by-one needs no flops
  if (COUNT_DIV_LOG2 == 0) begin : g_nodiv
    assign tick = 1'b1;
  end else begin : g_div
    localparam int unsigned PW = COUNT_DIV_LOG2;
    logic [PW-1:0] prescaler;
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        prescaler <= '0;
      end else if (count_wr) begin
        prescaler <= '0;
      end else begin
        prescaler <= prescaler + PW'(1);
      end
    end
    assign tick = &prescaler;
  end

  // Count/Compare and sticky TI; a Compare write clears TI over a same-edge match
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count   <= 32'd0;
      compare <= 32'd0;
      ti      <= 1'b0;
    end else begin
      if (count_wr) begin
        count <= cp0_in;
      end else if (tick) begin
        count <= count_inc;
      end
      if (compare_wr) begin
        compare <= cp0_in;
      end
      if (compare_wr) begin
        ti <= 1'b0;
      end else if (tick && !count_wr && (count_inc == compare)) begin
        ti <= 1'b1;
      end
    end
  end

  assign count_rd   = count;
  assign compare_rd = compare;
`else
  assign ti         = 1'b0;
  assign count_rd   = 32'd0;
  assign compare_rd = 32'd0;
`endif

  // mfc0 read mux
  always_comb begin
    logic [31:0] sr_val;
    logic [31:0] cause_val;
    sr_val                       = 32'd0;
    sr_val[IP_LSB +: HWINT_W]    = sr_im;
    sr_val[1]                    = sr_exl;
    sr_val[0]                    = sr_ie;
    cause_val                    = 32'd0;
    cause_val[31]                = cause_bd;
    cause_val[30]                = ti;
    cause_val[IP_LSB +: HWINT_W] = cause_ip;
    cause_val[6:2]               = cause_exc;
    case (reg_ra)
      A_BADVADDR: cp0_out = bad_vaddr;
      A_COUNT:    cp0_out = count_rd;
      A_COMPARE:  cp0_out = compare_rd;
      A_SR:       cp0_out = sr_val;
      A_CAUSE:    cp0_out = cause_val;
      A_EPC:      cp0_out = epc;
      A_PRID:     cp0_out = PRID;
      default:    cp0_out = 32'd0;
    endcase
  end

  assign epc_out = epc;

endmodule

// File: tb/tb_cp0_ext.sv
// Directed self-checking bench for cp0_ext; timer scenario included when CP0_TIMER_EN is defined.
module tb_cp0_ext;

  logic        clk;
  logic        reset;
  logic        we;
  logic [31:0] cp0_in;
  logic [4:0]  reg_wa;
  logic [4:0]  reg_ra;
  logic [5:0]  hwint;
  logic [31:0] pc;
  logic        bd_in;
  logic        exl_clr;
  logic [4:0]  exc_code_in;
  logic [31:0] bad_vaddr_in;
  logic        req;
  logic [31:0] cp0_out;
  logic [31:0] epc_out;

  int n_total = 0;
  int n_bad   = 0;

  cp0_ext dut (
    .clk(clk), .reset(reset), .we(we), .cp0_in(cp0_in), .reg_wa(reg_wa),
    .reg_ra(reg_ra), .hwint(hwint), .pc(pc), .bd_in(bd_in), .exl_clr(exl_clr),
    .exc_code_in(exc_code_in), .bad_vaddr_in(bad_vaddr_in), .req(req),
    .cp0_out(cp0_out), .epc_out(epc_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reg(input string tag, input logic [4:0] a, input logic [31:0] exp);
    reg_ra = a;
    #1;
    chk(tag, cp0_out, exp);
  endtask

  task automatic chk_req(input string tag, input logic exp);
    #1;
    chk(tag, 32'(req), 32'(exp));
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    we = 1'b1; reg_wa = a; cp0_in = d;
    step();
    we = 1'b0;
  endtask

  task automatic eret();
    exl_clr = 1'b1;
    step();
    exl_clr = 1'b0;
  endtask

  initial begin
    reset = 1'b0; we = 1'b0; cp0_in = 32'd0; reg_wa = 5'd0; reg_ra = 5'd12;
    hwint = 6'd0; pc = 32'd0; bd_in = 1'b0; exl_clr = 1'b0;
    exc_code_in = 5'h1F; bad_vaddr_in = 32'd0;
    #12;
    chk("rst_req", 32'(req), 32'd0);
    chk("rst_epc", epc_out, 32'd0);
    chk_reg("rst_sr", 5'd12, 32'd0);
    chk_reg("rst_cause", 5'd13, 32'd0);
    reset = 1'b1;
    step();

    // Hardware interrupt on line 0
    mtc0(5'd12, 32'h0000_0401);
    chk_reg("sr_wr", 5'd12, 32'h0000_0401);
    hwint = 6'h01; pc = 32'h0000_1000;
    chk_req("int_req", 1'b1);
    step();
    hwint = 6'h00;
    chk_reg("int_cause", 5'd13, 32'h0000_0400);
    chk_reg("int_sr", 5'd12, 32'h0000_0403);
    chk("int_epc", epc_out, 32'h0000_1000);
    eret();
    chk_reg("eret_sr", 5'd12, 32'h0000_0401);

    // Delay-slot AdEL captures BadVAddr
    exc_code_in = 5'd4; bd_in = 1'b1; pc = 32'h0000_3008; bad_vaddr_in = 32'h0000_1001;
    chk_req("adel_req", 1'b1);
    step();
    exc_code_in = 5'h1F; bd_in = 1'b0;
    chk("adel_epc", epc_out, 32'h0000_3004);
    chk_reg("adel_cause", 5'd13, 32'h8000_0010);
    chk_reg("adel_bva", 5'd8, 32'h0000_1001);
    exc_code_in = 5'd12; pc = 32'h0000_7000;
    chk_req("exl_block", 1'b0);
    step();
    exc_code_in = 5'h1F;
    chk("exl_epc_hold", epc_out, 32'h0000_3004);
    eret();

    // Interrupt beats AdES; BadVAddr must not move
    hwint = 6'h01; exc_code_in = 5'd5; pc = 32'h0000_2000; bad_vaddr_in = 32'h0000_5555;
    chk_req("prio_req", 1'b1);
    step();
    hwint = 6'h00; exc_code_in = 5'h1F;
    chk_reg("prio_cause", 5'd13, 32'h0000_0400);
    chk_reg("prio_bva", 5'd8, 32'h0000_1001);
    chk("prio_epc", epc_out, 32'h0000_2000);
    eret();

    // eret and mtc0 SR in the same cycle as an interrupt
    hwint = 6'h01; exl_clr = 1'b1; we = 1'b1; reg_wa = 5'd12; cp0_in = 32'd0; pc = 32'h0000_4000;
    chk_req("eret_int_req", 1'b1);
    step();
    hwint = 6'h00; exl_clr = 1'b0; we = 1'b0;
    chk_reg("eret_int_sr", 5'd12, 32'h0000_0403);
    chk("eret_int_epc", epc_out, 32'h0000_4000);
    eret();

    // EPC write, no bypass
    we = 1'b1; reg_wa = 5'd14; cp0_in = 32'h1234_5678;
    chk_reg("epc_nobypass", 5'd14, 32'h0000_4000);
    step();
    we = 1'b0;
    chk("epc_wr", epc_out, 32'h1234_5678);

    exc_code_in = 5'd0;
    chk_req("code0_none", 1'b0);
    exc_code_in = 5'h1F;

    // Read-only and unmapped addresses
    mtc0(5'd13, 32'hFFFF_FFFF);
    chk_reg("cause_ro", 5'd13, 32'h0000_0000);
    mtc0(5'd15, 32'd0);
    chk_reg("prid_ro", 5'd15, 32'h2237_3053);
    mtc0(5'd8, 32'd0);
    chk_reg("bva_ro", 5'd8, 32'h0000_1001);
    chk_reg("unmapped", 5'd3, 32'd0);
`ifndef CP0_TIMER_EN
    mtc0(5'd9, 32'h0000_0077);
    chk_reg("count_absent", 5'd9, 32'd0);
`endif

    // Masking
    mtc0(5'd12, 32'h0000_0400);
    hwint = 6'h01;
    chk_req("ie_off", 1'b0);
    hwint = 6'h00;
    mtc0(5'd12, 32'hFFFF_FFFF);
    chk_reg("sr_mask", 5'd12, 32'h0000_FC03);
    mtc0(5'd12, 32'h0000_8001);
    hwint = 6'h20;
    chk_req("line5_req", 1'b1);
    hwint = 6'h01;
    chk_req("line0_masked", 1'b0);

    // Async reset mid-cycle with EXL set
    hwint = 6'h20; pc = 32'h0000_5000;
    step();
    hwint = 6'h00;
    chk("pre_rst_epc", epc_out, 32'h0000_5000);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_epc", epc_out, 32'd0);
    chk("arst_req", 32'(req), 32'd0);
    chk_reg("arst_sr", 5'd12, 32'd0);
    chk_reg("arst_prid", 5'd15, 32'h2237_3053);
    reset = 1'b1;
    step();

`ifdef CP0_TIMER_EN
    // Count=0, Compare=5, IM[15]/IE enabled
    mtc0(5'd9, 32'd0);
    mtc0(5'd11, 32'd5);
    mtc0(5'd12, 32'h0000_8001);
    for (int i = 3; i <= 5; i++) begin
      step();
      chk_req($sformatf("tmr_req_%0d", i), (i == 5));
    end
    chk_reg("tmr_cause", 5'd13, 32'h4000_0000);
    chk_reg("tmr_count", 5'd9, 32'd5);
    step();
    chk_reg("tmr_sr", 5'd12, 32'h0000_8003);
    mtc0(5'd11, 32'd5);
    chk_reg("tmr_ti_clr", 5'd13, 32'h0000_0000);
    eret();
    for (int i = 0; i < 4; i++) begin
      chk_req($sformatf("tmr_noretrig_%0d", i), 1'b0);
      step();
    end
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
